tick_scheduler: RTL

//  Central game-tick scheduler. Divides the 100 MHz clock to a fixed base tick,

---
 rtl/tick_scheduler.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/tick_scheduler.sv
// Game-tick scheduler: divides the system clock to a base tick, runs one
// programmable period counter per channel, and grants the shared update
// datapath to one due channel at a time in round-robin order. A grant ends
// on the consumer's done handshake or after TO_TICKS base ticks.
module tick_scheduler #(
  parameter int CLK_HZ   = 100_000_000,
  parameter int BASE_HZ  = 1000,
  parameter int N_CH     = 4,
  parameter int PW       = 10,
  parameter int TO_TICKS = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    period_we_i,
  input  logic [$clog2(N_CH)-1:0] period_sel_i,
  input  logic [PW-1:0]           period_val_i,
  input  logic                    pause_i,
  input  logic                    done_i,
  output logic                    base_tick_o,
  output logic [N_CH-1:0]         grant_o,
  output logic                    busy_o,
  output logic [N_CH-1:0]         overrun_o,
  output logic                    timeout_err_o
);

  localparam int DIV = CLK_HZ / BASE_HZ;
  localparam int DW  = $clog2(DIV);
  localparam int TW  = $clog2(TO_TICKS + 1);
  localparam int IW  = $clog2(N_CH);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t          state_q;
  logic [DW-1:0]   pre_q;
  logic [TW-1:0]   to_q;
  logic [IW-1:0]   rr_q;
  logic [PW-1:0]   period_q [N_CH];
  logic [PW-1:0]   period_d [N_CH];
  logic [PW-1:0]   cnt_q    [N_CH];
  logic [PW-1:0]   cnt_d    [N_CH];
  logic [N_CH-1:0] pending_q, pending_d;
  logic [N_CH-1:0] overrun_q, overrun_d;
  logic [IW-1:0]   pick_idx;
  logic            pick_ok;
  logic            grant_fire;

  // Base tick fires in the last count of each prescaler cycle; pause gates it.
  assign base_tick_o = !pause_i && (pre_q == DW'(DIV - 1));
  assign overrun_o   = overrun_q;
  assign grant_fire  = (state_q == S_IDLE) && pick_ok;

  // Prescaler: free-running 0..DIV-1 counter that holds while paused.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q <= '0;
    end else if (!pause_i) begin
      pre_q <= base_tick_o ? '0 : pre_q + DW'(1);
    end
  end

  // Round-robin pick: first pending channel at or after the rr pointer.
  always_comb begin
    // NOTE: combinational blocks use blocking assignments and give every
    // output a default first, so no path leaves a value held (no latch).
    pick_ok  = 1'b0;
    pick_idx = '0;
    for (int j = 0; j < N_CH; j++) begin
      if (!pick_ok && pending_q[IW'((int'(rr_q) + j) % N_CH)]) begin
        pick_ok  = 1'b1;
        pick_idx = IW'((int'(rr_q) + j) % N_CH);
      end
    end
  end

  // Channel next state: period writes beat ticks, and a new due beats the
  // pending clear of a same-cycle grant (without counting as overrun).
  always_comb begin
    period_d  = period_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    overrun_d = overrun_q;
    if (grant_fire) pending_d[pick_idx] = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (period_we_i && (period_sel_i == IW'(i))) begin
        period_d[i] = period_val_i;
        cnt_d[i]    = period_val_i;
        if (period_val_i == '0) pending_d[i] = 1'b0;
      end else if (base_tick_o && (period_q[i] != '0)) begin
        if (cnt_q[i] <= PW'(1)) begin
          cnt_d[i] = period_q[i];
          if (pending_q[i] && !(grant_fire && (pick_idx == IW'(i))))
            overrun_d[i] = 1'b1;
          pending_d[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] - PW'(1);
        end
      end
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: these per-channel arrays are a handful of flops, not RAM, so
      // they take the async reset like any other state (channels disabled).
      for (int i = 0; i < N_CH; i++) begin
        period_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      pending_q <= '0;
      overrun_q <= '0;
    end else begin
      // NOTE: sequential state is updated only with non-blocking assignments.
      period_q  <= period_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  // Grant FSM with registered grant, busy and timeout pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      grant_o       <= '0;
      busy_o        <= 1'b0;
      timeout_err_o <= 1'b0;
      rr_q          <= '0;
      to_q          <= '0;
    end else begin
      timeout_err_o <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (grant_fire) begin
            grant_o <= N_CH'(1) << pick_idx;
            rr_q    <= IW'((int'(pick_idx) + 1) % N_CH);
            busy_o  <= 1'b1;
            to_q    <= '0;
            state_q <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (done_i) begin
            grant_o <= '0;
            busy_o  <= 1'b0;
            state_q <= S_IDLE;
          end else if (base_tick_o) begin
            if (to_q == TW'(TO_TICKS - 1)) begin
              grant_o       <= '0;
              busy_o        <= 1'b0;
              timeout_err_o <= 1'b1;
              state_q       <= S_IDLE;
            end else begin
              to_q <= to_q + TW'(1);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
